sys_ctrl_fsm: RTL and testbench
===============================

Name: sys_ctrl_fsm

Overview:
Command-decoding controller that sits directly upstream of the register file. It consumes bytes from the UART receive path, decodes register write and read frames, and drives the register file's WrEn/RdEn/Address/WrData. It captures RdData when RdData_Valid arrives and forwards the value to the TX FIFO. An optional ALU command path can be compiled in.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX data and register data
ADDR_WIDTH, 4, register file address width; upper address-byte bits are ignored
RD_TIMEOUT, 15, maximum cycles to wait for RdData_Valid before abort

Ports:
clk  input  1  system clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte
RX_D_VLD  input  1  one-cycle strobe: RX_P_DATA valid
RdData  input  DATA_WIDTH  register file read data
RdData_Valid  input  1  register file read-data strobe
FIFO_FULL  input  1  TX FIFO full
WrEn  output  1  register write enable, one-cycle pulse
RdEn  output  1  register read enable, one-cycle pulse
Address  output  ADDR_WIDTH  register address
WrData  output  DATA_WIDTH  register write data
TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  output  1  TX FIFO write strobe
CMD_ERR  output  1  one-cycle error pulse
ALU_EN, ALU_FUN[3:0], ALU_OUT[2*DATA_WIDTH-1:0] in, ALU_OUT_VLD in  (present only with SYS_CTRL_ALU_EN)

Behaviour:
- Reset is asynchronous and active-low. While RST=0, all outputs are 0, the FSM is in IDLE, and all internal registers are 0. If reset asserts mid-frame, the frame is abandoned and no partial write occurs.
- All outputs are registered and driven from flops.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND (plus ALU states when the optional feature is compiled in).
- In IDLE, a byte is consumed only when RX_D_VLD=1:
  - 0xAA moves to WR_ADDR.
  - 0xBB moves to RD_ADDR.
  - Any other value stays in IDLE and pulses CMD_ERR in the next cycle.
- WR_ADDR: on RX_D_VLD, latch RX_P_DATA[ADDR_WIDTH-1:0] into Address, then go to WR_DATA.
- WR_DATA: on RX_D_VLD, WrData=RX_P_DATA and WrEn=1 for exactly one cycle, in the cycle after the strobe. Return to IDLE. A new command byte in that cycle is accepted.
- RD_ADDR: on RX_D_VLD, latch the address and pulse RdEn for one cycle in the next cycle. Go to RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - The counter increments each cycle.
  - On RdData_Valid, latch RdData and go to TX_SEND. The nominal RdData_Valid arrives 1 cycle after RdEn.
  - If the counter reaches RD_TIMEOUT without RdData_Valid, pulse CMD_ERR and go to IDLE.
  - The counter saturates and never wraps.
- TX_SEND:
  - While FIFO_FULL=1, hold state with TX_D_VLD=0.
  - The first cycle with FIFO_FULL=0 drives TX_P_DATA=the latched byte and TX_D_VLD=1 for exactly one cycle, then goes to IDLE.
  - Minimum read latency, from the address-byte strobe to TX_D_VLD, is 3 cycles.
- RX_D_VLD received in RD_WAIT or TX_SEND: the byte is dropped and CMD_ERR pulses. The state is unaffected.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their last values between operations.

Optional Feature:
Macro SYS_CTRL_ALU_EN.
- Defined:
  - The ALU ports exist and states ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_LO, TX_HI are added.
  - 0xCC takes three bytes: OPA is written to register 0 and OPB to register 1, each via a one-cycle WrEn. The FUN byte then drives ALU_FUN=FUN[3:0] with a one-cycle ALU_EN pulse.
  - 0xDD takes the FUN byte only and uses the existing register operands.
  - ALU_WAIT waits for ALU_OUT_VLD, with the same RD_TIMEOUT rule.
  - Result transmit sends the low byte, then the high byte, each obeying the FIFO_FULL rule, then returns to IDLE.
- Undefined:
  - The ALU ports are absent.
  - 0xCC and 0xDD are unknown commands: pulse CMD_ERR and stay in IDLE.

Test Plan:
- Reset: hold RST=0 for 3 cycles mid-WR_DATA, then release -> all outputs 0, state IDLE, no WrEn seen.
- Write: bytes 0xAA, 0x05, 0x3C -> one-cycle WrEn with Address=5, WrData=0x3C, one cycle after the third strobe.
- Read: 0xBB, 0x02; RdData=0x81 with RdData_Valid 1 cycle after RdEn, FIFO_FULL=0 -> TX_P_DATA=0x81, TX_D_VLD pulse 3 cycles after the address strobe.
- Backpressure and timeout:
  - Read with FIFO_FULL=1 for 5 cycles -> TX_D_VLD held low, then a single pulse in the first free cycle.
  - Read with RdData_Valid never asserted -> CMD_ERR pulse after 15 cycles, FSM back in IDLE.
- Bad input:
  - Unknown byte 0x11 in IDLE -> CMD_ERR pulse, no WrEn/RdEn.
  - Byte during RD_WAIT -> CMD_ERR, read still completes.
- With SYS_CTRL_ALU_EN: 0xCC, 0x0A, 0x03, 0x00; ALU_OUT=0x000D -> WrEn to addresses 0 and 1, ALU_EN with ALU_FUN=0, then TX bytes 0x0D then 0x00.

Source files
------------

// File: rtl/sys_ctrl_fsm_if.sv
// Register-file / UART / TX-FIFO bundle for sys_ctrl_fsm; ALU signals exist only with SYS_CTRL_ALU_EN.
interface sys_ctrl_fsm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic                    FIFO_FULL;
  logic                    WrEn;
  logic                    RdEn;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WrData;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    CMD_ERR;
`ifdef SYS_CTRL_ALU_EN
  logic                    ALU_EN;
  logic [3:0]              ALU_FUN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
`endif

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, FIFO_FULL,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
`ifdef SYS_CTRL_ALU_EN
    , output ALU_EN, ALU_FUN
    , input  ALU_OUT, ALU_OUT_VLD
`endif
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, FIFO_FULL,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
`ifdef SYS_CTRL_ALU_EN
    , input  ALU_EN, ALU_FUN
    , output ALU_OUT, ALU_OUT_VLD
`endif
  );
endinterface

// File: rtl/sys_ctrl_fsm.sv
// UART command decoder driving register-file writes/reads and forwarding read data to the TX FIFO.
// Optional ALU command path (0xCC/0xDD) compiled in with macro SYS_CTRL_ALU_EN.
module sys_ctrl_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           RST,
  sys_ctrl_fsm_if.master bus
);
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_TX_SEND  = 4'd5;
  localparam logic [3:0] ST_ALU_OPA  = 4'd6;
  localparam logic [3:0] ST_ALU_OPB  = 4'd7;
  localparam logic [3:0] ST_ALU_FUN  = 4'd8;
  localparam logic [3:0] ST_ALU_WAIT = 4'd9;
  localparam logic [3:0] ST_TX_LO    = 4'd10;
  localparam logic [3:0] ST_TX_HI    = 4'd11;

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
`ifdef SYS_CTRL_ALU_EN
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_FUN = DATA_WIDTH'(8'hDD);
  logic [DATA_WIDTH-1:0] res_hi;
`endif

  logic [3:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  timed_out;

  // Timeout fires on the RD_TIMEOUT-th waiting cycle without a response.
  assign timed_out = (cnt == CW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      tx_byte       <= '0;
      bus.WrEn      <= 1'b0;
      bus.RdEn      <= 1'b0;
      bus.Address   <= '0;
      bus.WrData    <= '0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD  <= 1'b0;
      bus.CMD_ERR   <= 1'b0;
`ifdef SYS_CTRL_ALU_EN
      res_hi        <= '0;
      bus.ALU_EN    <= 1'b0;
      bus.ALU_FUN   <= '0;
`endif
    end else begin
      bus.WrEn     <= 1'b0;
      bus.RdEn     <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      bus.CMD_ERR  <= 1'b0;
`ifdef SYS_CTRL_ALU_EN
      bus.ALU_EN   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (bus.RX_D_VLD) begin
            if (bus.RX_P_DATA == CMD_WR) state <= ST_WR_ADDR;
            else if (bus.RX_P_DATA == CMD_RD) state <= ST_RD_ADDR;
`ifdef SYS_CTRL_ALU_EN
            else if (bus.RX_P_DATA == CMD_ALU_OPS) state <= ST_ALU_OPA;
            else if (bus.RX_P_DATA == CMD_ALU_FUN) state <= ST_ALU_FUN;
`endif
            else bus.CMD_ERR <= 1'b1;
          end
        end
        ST_WR_ADDR: begin
          if (bus.RX_D_VLD) begin
            bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
            state       <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (bus.RX_D_VLD) begin
            bus.WrData <= bus.RX_P_DATA;
            bus.WrEn   <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (bus.RX_D_VLD) begin
            bus.Address <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
            bus.RdEn    <= 1'b1;
            cnt         <= '0;
            state       <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (bus.RX_D_VLD) bus.CMD_ERR <= 1'b1;
          if (bus.RdData_Valid) begin
            tx_byte <= bus.RdData;
            // A free FIFO lets the byte go straight out, giving the 3-cycle read path.
            if (!bus.FIFO_FULL) begin
              bus.TX_P_DATA <= bus.RdData;
              bus.TX_D_VLD  <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              state <= ST_TX_SEND;
            end
          end else if (timed_out) begin
            bus.CMD_ERR <= 1'b1;
            state       <= ST_IDLE;
          end else if (cnt != CW'(RD_TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TX_SEND: begin
          if (bus.RX_D_VLD) bus.CMD_ERR <= 1'b1;
          if (!bus.FIFO_FULL) begin
            bus.TX_P_DATA <= tx_byte;
            bus.TX_D_VLD  <= 1'b1;
            state         <= ST_IDLE;
          end
        end
`ifdef SYS_CTRL_ALU_EN
        ST_ALU_OPA, ST_ALU_OPB: begin
          if (bus.RX_D_VLD) begin
            bus.Address <= (state == ST_ALU_OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
            bus.WrData  <= bus.RX_P_DATA;
            bus.WrEn    <= 1'b1;
            state       <= (state == ST_ALU_OPA) ? ST_ALU_OPB : ST_ALU_FUN;
          end
        end
        ST_ALU_FUN: begin
          if (bus.RX_D_VLD) begin
            bus.ALU_FUN <= bus.RX_P_DATA[3:0];
            bus.ALU_EN  <= 1'b1;
            cnt         <= '0;
            state       <= ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (bus.RX_D_VLD) bus.CMD_ERR <= 1'b1;
          if (bus.ALU_OUT_VLD) begin
            {res_hi, tx_byte} <= bus.ALU_OUT;
            state             <= ST_TX_LO;
          end else if (timed_out) begin
            bus.CMD_ERR <= 1'b1;
            state       <= ST_IDLE;
          end else if (cnt != CW'(RD_TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TX_LO, ST_TX_HI: begin
          if (bus.RX_D_VLD) bus.CMD_ERR <= 1'b1;
          if (!bus.FIFO_FULL) begin
            bus.TX_P_DATA <= (state == ST_TX_LO) ? tx_byte : res_hi;
            bus.TX_D_VLD  <= 1'b1;
            state         <= (state == ST_TX_LO) ? ST_TX_HI : ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// Scoreboard bench for sys_ctrl_fsm: directed frames push expected events, a negedge monitor pops them.
module tb_sys_ctrl_fsm;
  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_fsm_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
  sys_ctrl_fsm #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(15)) dut (
    .clk(clk), .RST(RST), .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t tx_q[$];
  ev_t err_q[$];
  ev_t alu_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic       rd_on = 1'b1;
  logic [7:0] rd_val = 8'h00;
  logic       rden_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b, output int s);
    bus.RX_D_VLD  = 1'b1;
    bus.RX_P_DATA = b;
    s = cyc;
    @(posedge clk); #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Register file model: answers one cycle after RdEn unless disabled.
  initial forever begin
    @(posedge clk); #1;
    bus.RdData_Valid = rden_d & rd_on;
    bus.RdData       = rd_val;
    rden_d           = bus.RdEn;
  end

`ifdef SYS_CTRL_ALU_EN
  logic alu_d = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    bus.ALU_OUT_VLD = alu_d;
    bus.ALU_OUT     = 16'h000D;
    alu_d           = bus.ALU_EN;
  end
`endif

  always @(negedge clk) begin
    if (RST) begin
      ev_t e;
      chk("wr_rd_excl", 32'(bus.WrEn & bus.RdEn), 32'd0);
      if (bus.WrEn) begin
        chk("wr_unexpected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          chk("wr_cyc", 32'(cyc), 32'(e.cyc));
          chk("wr_addr", 32'(bus.Address), 32'(e.a));
          chk("wr_data", 32'(bus.WrData), 32'(e.d));
        end
      end
      if (bus.RdEn) begin
        chk("rd_unexpected", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) begin
          e = rd_q.pop_front();
          chk("rd_cyc", 32'(cyc), 32'(e.cyc));
          chk("rd_addr", 32'(bus.Address), 32'(e.a));
        end
      end
      if (bus.TX_D_VLD) begin
        chk("tx_unexpected", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0) begin
          e = tx_q.pop_front();
          chk("tx_cyc", 32'(cyc), 32'(e.cyc));
          chk("tx_data", 32'(bus.TX_P_DATA), 32'(e.d));
        end
      end
      if (bus.CMD_ERR) begin
        chk("err_unexpected", 32'(err_q.size() > 0), 32'd1);
        if (err_q.size() > 0) begin
          e = err_q.pop_front();
          chk("err_cyc", 32'(cyc), 32'(e.cyc));
        end
      end
`ifdef SYS_CTRL_ALU_EN
      if (bus.ALU_EN) begin
        chk("alu_unexpected", 32'(alu_q.size() > 0), 32'd1);
        if (alu_q.size() > 0) begin
          e = alu_q.pop_front();
          chk("alu_cyc", 32'(cyc), 32'(e.cyc));
          chk("alu_fun", 32'(bus.ALU_FUN), 32'(e.d));
        end
      end
`endif
    end
  end

  function automatic logic [31:0] outs();
    logic [31:0] v;
    v = 32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.TX_P_DATA, bus.TX_D_VLD, bus.CMD_ERR});
`ifdef SYS_CTRL_ALU_EN
    v = v | 32'({bus.ALU_EN, bus.ALU_FUN});
`endif
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s1, s2, s3;
    bus.RX_D_VLD     = 1'b0;
    bus.RX_P_DATA    = 8'h00;
    bus.FIFO_FULL    = 1'b0;
    bus.RdData       = 8'h00;
    bus.RdData_Valid = 1'b0;
`ifdef SYS_CTRL_ALU_EN
    bus.ALU_OUT      = 16'h0000;
    bus.ALU_OUT_VLD  = 1'b0;
`endif
    idle(3);
    chk("reset_outputs", outs(), 32'd0);
    RST = 1'b1;
    idle(2);

    // Plain write, then a read command accepted in the WrEn cycle.
    send(8'hAA, s); send(8'h05, s); send(8'h3C, s);
    wr_q.push_back('{cyc: s + 1, a: 8'h05, d: 8'h3C});
    rd_val = 8'h81;
    send(8'hBB, s); send(8'h02, s);
    rd_q.push_back('{cyc: s + 1, a: 8'h02, d: 8'h00});
    tx_q.push_back('{cyc: s + 3, a: 8'h00, d: 8'h81});
    idle(5);
    chk("addr_hold", 32'(bus.Address), 32'h2);
    chk("wrdata_hold", 32'(bus.WrData), 32'h3C);

    // Byte dropped during RD_WAIT; read still completes.
    rd_val = 8'h42;
    send(8'hBB, s); send(8'h07, s);
    rd_q.push_back('{cyc: s + 1, a: 8'h07, d: 8'h00});
    tx_q.push_back('{cyc: s + 3, a: 8'h00, d: 8'h42});
    send(8'h55, s1);
    err_q.push_back('{cyc: s1 + 1, a: 8'h00, d: 8'h00});
    idle(5);

    // FIFO backpressure, with a byte dropped in TX_SEND.
    rd_val = 8'h9E;
    bus.FIFO_FULL = 1'b1;
    send(8'hBB, s); send(8'h0A, s);
    rd_q.push_back('{cyc: s + 1, a: 8'h0A, d: 8'h00});
    idle(2);
    send(8'h77, s1);
    err_q.push_back('{cyc: s1 + 1, a: 8'h00, d: 8'h00});
    idle(1);
    bus.FIFO_FULL = 1'b0;
    tx_q.push_back('{cyc: s + 6, a: 8'h00, d: 8'h9E});
    idle(5);

    // Read timeout, then a write proves the FSM is back in IDLE.
    rd_on = 1'b0;
    send(8'hBB, s); send(8'h03, s);
    rd_q.push_back('{cyc: s + 1, a: 8'h03, d: 8'h00});
    err_q.push_back('{cyc: s + 16, a: 8'h00, d: 8'h00});
    idle(20);
    rd_on = 1'b1;
    send(8'hAA, s); send(8'h1E, s); send(8'h5A, s);
    wr_q.push_back('{cyc: s + 1, a: 8'h0E, d: 8'h5A});
    idle(3);

    // Unknown command.
    send(8'h11, s);
    err_q.push_back('{cyc: s + 1, a: 8'h00, d: 8'h00});
    idle(3);

`ifdef SYS_CTRL_ALU_EN
    send(8'hCC, s); send(8'h0A, s1); send(8'h03, s2); send(8'h00, s3);
    wr_q.push_back('{cyc: s1 + 1, a: 8'h00, d: 8'h0A});
    wr_q.push_back('{cyc: s2 + 1, a: 8'h01, d: 8'h03});
    alu_q.push_back('{cyc: s3 + 1, a: 8'h00, d: 8'h00});
    tx_q.push_back('{cyc: s3 + 4, a: 8'h00, d: 8'h0D});
    tx_q.push_back('{cyc: s3 + 5, a: 8'h00, d: 8'h00});
    idle(8);
    send(8'hDD, s); send(8'h05, s3);
    alu_q.push_back('{cyc: s3 + 1, a: 8'h00, d: 8'h05});
    tx_q.push_back('{cyc: s3 + 4, a: 8'h00, d: 8'h0D});
    tx_q.push_back('{cyc: s3 + 5, a: 8'h00, d: 8'h00});
    idle(8);
`else
    send(8'hCC, s);
    err_q.push_back('{cyc: s + 1, a: 8'h00, d: 8'h00});
    send(8'hDD, s);
    err_q.push_back('{cyc: s + 1, a: 8'h00, d: 8'h00});
    idle(3);
`endif

    // Reset mid-WR_DATA abandons the frame.
    send(8'hAA, s); send(8'h09, s);
    RST = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), 32'd0);
    idle(3);
    chk("rst_hold_outputs", outs(), 32'd0);
    RST = 1'b1;
    idle(1);
    send(8'h3C, s);
    err_q.push_back('{cyc: s + 1, a: 8'h00, d: 8'h00});
    idle(3);
    chk("addr_after_reset", 32'(bus.Address), 32'd0);

    idle(10);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);
    chk("tx_q_left", 32'(tx_q.size()), 32'd0);
    chk("err_q_left", 32'(err_q.size()), 32'd0);
    chk("alu_q_left", 32'(alu_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
